fifo_wr_sched: RTL and testbench

- Write-side scheduler for the async FIFO. Shares the single FIFO write port between NREQ requesters using round-robin.
- Grants a whole burst only when the FIFO has room for it. Free space is computed from the read pointer already synchronized into the write domain (wq2_rptr).
- Owns the write pointer: binary address plus Gray pointer exported to the read domain, and the full flag.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 25 ++
 rtl/fifo_wr_sched.sv | 134 +++++++++++++
 tb/tb_fifo_wr_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write/read schedulers: pointer
// encodings, depth derivation and the write-scheduler state encoding.
package fifo_pkg;

    // Pointer helpers operate on a fixed wide vector; callers slice off what they need.
    localparam int PTR_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } wr_state_e;

    function automatic int depth_of(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index strictly after the
// last winner, wrapping around.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IDXW-1:0] i_last,
    output logic            o_valid,
    output logic [IDXW-1:0] o_idx
);

    // Scan from farthest to nearest so the nearest eligible index is the one left standing.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_elig[(int'(i_last) + k) % NREQ]) begin
                o_valid = 1'b1;
                o_idx   = IDXW'((int'(i_last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-side scheduler: round-robin burst grants onto the single FIFO write
// port, granted only when the whole burst fits; owns wbin/wptr/wfull.
module fifo_wr_sched
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int LENW     = 5
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LENW-1:0]  req_len,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [ADDRSIZE:0]     wq2_rptr,
    output logic [NREQ-1:0]       gnt,
    output logic                  winc,
    output logic [ADDRSIZE-1:0]   waddr,
    output logic [DSIZE-1:0]      wdata,
    output logic [ADDRSIZE:0]     wptr,
    output logic                  wfull,
    output logic                  len_err
);

    localparam int DEPTH = depth_of(ADDRSIZE);
    localparam int PW    = ADDRSIZE + 1;
    localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    wr_state_e         r_state, w_next;
    logic [IDXW-1:0]   r_cand, r_rr, w_arb_idx;
    logic              w_arb_valid;
    logic [LENW-1:0]   r_cand_len, r_cnt;
    logic [PW-1:0]     r_wbin, r_wptr, w_rbin, w_used, w_free, w_wbin_next, w_wgray_next;
    logic              r_wfull, r_len_err, w_fits, w_full_next, w_winc;
    logic [NREQ-1:0]   r_req_q, w_elig, w_illegal;
    logic [LENW-1:0]   w_len [NREQ];
    logic [PTR_MAX-1:0] w_rbin_wide, w_gray_wide;
    logic              w_unused_hi;

    always_comb begin
        w_elig    = '0;
        w_illegal = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_len[i]     = req_len[i*LENW +: LENW];
            w_illegal[i] = (w_len[i] == '0) || (w_len[i] > LENW'(DEPTH));
            w_elig[i]    = req[i] && !w_illegal[i];
        end
    end

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .i_elig  (w_elig),
        .i_last  (r_rr),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    // Modular pointer arithmetic: used spans 0..DEPTH, so free does too.
    assign w_rbin_wide  = gray2bin(PTR_MAX'(wq2_rptr));
    assign w_rbin       = w_rbin_wide[PW-1:0];
    assign w_used       = r_wbin - w_rbin;
    assign w_free       = PW'(DEPTH) - w_used;
    assign w_fits       = (r_cand_len <= LENW'(w_free));
    assign w_winc       = (r_state == BURST);
    assign w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_winc};
    assign w_gray_wide  = bin2gray(PTR_MAX'(w_wbin_next));
    assign w_wgray_next = w_gray_wide[PW-1:0];
    assign w_unused_hi  = ^{w_rbin_wide[PTR_MAX-1:PW], w_gray_wide[PTR_MAX-1:PW]};
    assign w_full_next  = (w_wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_arb_valid) w_next = WAIT;
            WAIT: begin
                if (!req[r_cand])  w_next = IDLE;
                else if (w_fits)   w_next = BURST;
            end
            BURST:   if (r_cnt == LENW'(1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // The candidate stays locked in WAIT so shorter requests cannot starve it.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_cand     <= '0;
            r_cand_len <= '0;
            r_cnt      <= '0;
            r_rr       <= IDXW'(NREQ - 1);
            r_wbin     <= '0;
            r_wptr     <= '0;
            r_wfull    <= 1'b0;
            r_len_err  <= 1'b0;
            r_req_q    <= '0;
        end else begin
            r_wbin    <= w_wbin_next;
            r_wptr    <= w_wgray_next;
            r_wfull   <= w_full_next;
            r_req_q   <= req;
            r_len_err <= |(req & ~r_req_q & w_illegal);
            case (r_state)
                IDLE: if (w_arb_valid) begin
                    r_cand     <= w_arb_idx;
                    r_cand_len <= w_len[w_arb_idx];
                end
                WAIT: if (req[r_cand] && w_fits) r_cnt <= r_cand_len;
                BURST: begin
                    r_cnt <= r_cnt - LENW'(1);
                    if (r_cnt == LENW'(1)) r_rr <= r_cand;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (w_winc) gnt[r_cand] = 1'b1;
    end

    assign winc    = w_winc;
    assign waddr   = r_wbin[ADDRSIZE-1:0];
    assign wdata   = req_data[int'(r_cand)*DSIZE +: DSIZE];
    assign wptr    = r_wptr;
    assign wfull   = r_wfull;
    assign len_err = r_len_err;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: table-driven bursts plus hand sequences, with a
// scoreboard of expected {gnt, waddr, wdata} beats.
module tb_fifo_wr_sched;

    localparam int ADDRSIZE = 4;
    localparam int DSIZE    = 8;
    localparam int NREQ     = 4;
    localparam int LENW     = 5;
    localparam int PW       = ADDRSIZE + 1;
    localparam int EW       = NREQ + ADDRSIZE + DSIZE;

    typedef struct {
        int id;
        int len;
    } burst_t;

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LENW-1:0]  req_len = '0;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [PW-1:0]         wq2_rptr;
    logic [NREQ-1:0]       gnt;
    logic                  winc;
    logic [ADDRSIZE-1:0]   waddr;
    logic [DSIZE-1:0]      wdata;
    logic [PW-1:0]         wptr;
    logic                  wfull;
    logic                  len_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    int seq[NREQ];
    int plan_seq[NREQ];
    int m_wbin = 0;
    int rbin = 0;
    int beats = 0;
    int len_err_cnt = 0;
    int cyc = 0;
    int track = 0;
    int beat_cyc[$];

    fifo_wr_sched #(.ADDRSIZE(ADDRSIZE), .DSIZE(DSIZE), .NREQ(NREQ), .LENW(LENW)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_len  (req_len),
        .req_data (req_data),
        .wq2_rptr (wq2_rptr),
        .gnt      (gnt),
        .winc     (winc),
        .waddr    (waddr),
        .wdata    (wdata),
        .wptr     (wptr),
        .wfull    (wfull),
        .len_err  (len_err)
    );

    // ---------------- clock / reset ----------------
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] x;
        x = PW'(b);
        return x ^ (x >> 1);
    endfunction

    assign wq2_rptr = to_gray(rbin);

    // Requesters present {id, sequence} and advance on every granted cycle.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = {2'(i), 6'(seq[i])};
    end

    initial for (int i = 0; i < NREQ; i++) begin seq[i] = 0; plan_seq[i] = 0; end

    always @(posedge wclk) begin
        cyc++;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) seq[i]++;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Scoreboard: every write beat pops one expected {gnt, waddr, wdata}.
    always @(negedge wclk) begin
        if (!wrst) begin
            if (len_err) len_err_cnt++;
            if (winc) begin
                beats++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else chk("beat", 32'({gnt, waddr, wdata}), 32'(exp_q.pop_front()));
            end else begin
                chk("gnt_idle", 32'(gnt), 32'(0));
            end
            if (track != 0) rbin = beats;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_burst(input int id, input int len);
        logic [NREQ-1:0]  oh;
        logic [DSIZE-1:0] d;
        for (int k = 0; k < len; k++) begin
            oh = '0;
            oh[id] = 1'b1;
            d = {2'(id), 6'(plan_seq[id])};
            exp_q.push_back({oh, ADDRSIZE'(m_wbin), d});
            m_wbin++;
            plan_seq[id]++;
        end
    endtask

    task automatic set_len(input int id, input int len);
        req_len[id*LENW +: LENW] = LENW'(len);
    endtask

    task automatic wait_gnt(output int lat);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge wclk);
            lat++;
            if (gnt != '0) begin
                #1;
                return;
            end
        end
        lat = -1;
        fail_now("wait_gnt");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            @(negedge wclk);
            if (gnt == '0 && !winc) begin
                #1;
                return;
            end
        end
        fail_now("wait_idle");
    endtask

    task automatic no_gnt(input string name, input int cycles);
        int c;
        c = 0;
        repeat (cycles) begin
            @(negedge wclk);
            if (gnt != '0) c++;
        end
        #1;
        chk(name, c, 0);
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        req = '0;
        req_len = '0;
        track = 0;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_winc", 32'(winc), 0);
        chk("rst_wptr", 32'(wptr), 0);
        chk("rst_wfull", 32'(wfull), 0);
        chk("rst_len_err", 32'(len_err), 0);
        repeat (2) @(negedge wclk);
        exp_q.delete();
        m_wbin = 0;
        rbin = 0;
        beats = 0;
        for (int i = 0; i < NREQ; i++) plan_seq[i] = seq[i];
        #1 wrst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    burst_t t2[5];
    int lat;

    initial begin
        t2[0] = '{0, 2};
        t2[1] = '{1, 2};
        t2[2] = '{2, 2};
        t2[3] = '{3, 2};
        t2[4] = '{0, 2};

        // Single 4-beat burst into an empty FIFO.
        do_reset();
        push_burst(0, 4);
        set_len(0, 4);
        req[0] = 1'b1;
        wait_gnt(lat);
        chk("t1_latency", lat, 2);
        req[0] = 1'b0;
        wait_idle();
        chk("t1_beats", beats, 4);
        chk("t1_wptr", 32'(wptr), 32'(5'b00110));
        chk("t1_wfull", 32'(wfull), 0);

        // Table-driven round robin with the read side draining continuously.
        do_reset();
        track = 1;
        beat_cyc.delete();
        foreach (t2[i]) push_burst(t2[i].id, t2[i].len);
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        req = '1;
        for (int n = 0; n < 200 && beats < 9; n++) @(negedge wclk);
        if (beats < 9) fail_now("t2_progress");
        #1 req = '0;
        wait_idle();
        track = 0;
        chk("t2_beats", beats, 10);
        for (int b = 0; b < 5; b++) begin
            if (beat_cyc.size() >= 10) begin
                chk("t2_in_burst", beat_cyc[2*b+1] - beat_cyc[2*b], 1);
                if (b < 4) chk("t2_gap", beat_cyc[2*b+2] - beat_cyc[2*b+1], 3);
            end else begin
                fail_now("t2_beat_log");
            end
        end

        // Lack of space holds the candidate in WAIT until reads free room.
        do_reset();
        push_burst(0, 14);
        set_len(0, 14);
        req[0] = 1'b1;
        wait_gnt(lat);
        req[0] = 1'b0;
        wait_idle();
        chk("t3_wfull_14", 32'(wfull), 0);
        push_burst(1, 4);
        set_len(1, 4);
        req[1] = 1'b1;
        no_gnt("t3_wait_no_gnt", 10);
        rbin = 2;
        wait_gnt(lat);
        chk("t3_latency", lat, 1);
        req[1] = 1'b0;
        wait_idle();
        chk("t3_wfull", 32'(wfull), 1);
        chk("t3_wptr_wrap", 32'(wptr), 32'(5'b11011));

        // Abandoned candidate returns to IDLE without moving the rr pointer.
        rbin = 3;
        set_len(3, 2);
        req[3] = 1'b1;
        no_gnt("t4_wait_no_gnt", 5);
        req[3] = 1'b0;
        set_len(0, 1);
        set_len(2, 1);
        req[0] = 1'b1;
        req[2] = 1'b1;
        push_burst(2, 1);
        wait_gnt(lat);
        chk("t4_latency", lat, 3);
        chk("t4_gnt", 32'(gnt), 32'(4'b0100));
        req[2] = 1'b0;
        wait_idle();
        no_gnt("t4_req0_blocked", 6);
        chk("t4_wfull", 32'(wfull), 1);
        req[0] = 1'b0;

        // Illegal lengths are masked and flagged once per assertion.
        rbin = 19;
        len_err_cnt = 0;
        set_len(3, 0);
        set_len(1, 2);
        req[3] = 1'b1;
        req[1] = 1'b1;
        push_burst(1, 2);
        wait_gnt(lat);
        req[1] = 1'b0;
        wait_idle();
        repeat (3) @(negedge wclk);
        #1 req[3] = 1'b0;
        repeat (2) @(negedge wclk);
        #1 set_len(3, 17);
        req[3] = 1'b1;
        repeat (4) @(negedge wclk);
        #1 req[3] = 1'b0;
        repeat (2) @(negedge wclk);
        #1 chk("t5_len_err_cnt", len_err_cnt, 2);
        rbin = m_wbin;
        set_len(3, 16);
        req[3] = 1'b1;
        push_burst(3, 16);
        wait_gnt(lat);
        chk("t5_full_len_latency", lat, 2);
        req[3] = 1'b0;
        wait_idle();
        chk("t5_wfull_16", 32'(wfull), 1);
        chk("t5_len_err_final", len_err_cnt, 2);

        // Asynchronous reset during beat 2 of a 4-beat burst.
        rbin = m_wbin;
        set_len(1, 4);
        req[1] = 1'b1;
        push_burst(1, 4);
        wait_gnt(lat);
        req[1] = 1'b0;
        @(negedge wclk);
        #1 wrst = 1'b1;
        #1;
        chk("t6_gnt", 32'(gnt), 0);
        chk("t6_winc", 32'(winc), 0);
        chk("t6_wptr", 32'(wptr), 0);
        exp_q.delete();
        m_wbin = 0;
        rbin = 0;
        beats = 0;
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) plan_seq[i] = seq[i];
        #1 wrst = 1'b0;
        set_len(0, 1);
        set_len(1, 1);
        push_burst(0, 1);
        push_burst(1, 1);
        req[0] = 1'b1;
        req[1] = 1'b1;
        wait_gnt(lat);
        chk("t6_first_gnt", 32'(gnt), 32'(4'b0001));
        req[0] = 1'b0;
        wait_idle();
        wait_gnt(lat);
        req[1] = 1'b0;
        wait_idle();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
